// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packetizer.
// Build option PKT_CHECKSUM_EN adds an XOR checksum byte ahead of the trailer.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_STROBE    = 3'd3,
        ST_GAP       = 3'd4,
        ST_WAIT_DONE = 3'd5
    } pkt_state_t;

    localparam logic [7:0] DEF_HEADER  = 8'hBB;
    localparam logic [7:0] DEF_TRAILER = 8'hAA;

`ifdef PKT_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    // Header + payload + optional checksum + trailer.
    function automatic int pkt_len(input int num_ch, input int data_bytes, input bit cks);
        return num_ch * data_bytes + 2 + (cks ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_pkt_byte_sel.sv
// Combinational packet-byte lookup: maps a byte index to header, payload, checksum or trailer.
// The checksum input exists only when PKT_CHECKSUM_EN is defined.
module uart_pkt_byte_sel
    import uart_pkt_pkg::*;
#(
    parameter int         NUM_CH     = 1,
    parameter int         DATA_BYTES = 6,
    parameter logic [7:0] HEADER     = DEF_HEADER,
    parameter logic [7:0] TRAILER    = DEF_TRAILER,
    parameter int         IDX_W      = 4
) (
    input  logic [NUM_CH*DATA_BYTES*8-1:0] snapshot,
    input  logic [IDX_W-1:0]               idx,
`ifdef PKT_CHECKSUM_EN
    input  logic [7:0]                     checksum,
`endif
    output logic [7:0]                     pkt_byte
);

    localparam int NB = NUM_CH * DATA_BYTES;

    // Payload byte b sits at index b+1; channels are contiguous, LSB first.
    always_comb begin
        pkt_byte = TRAILER;
        if (idx == '0) begin
            pkt_byte = HEADER;
        end
        for (int b = 0; b < NB; b++) begin
            if (idx == IDX_W'(b + 1)) begin
                pkt_byte = snapshot[b*8 +: 8];
            end
        end
`ifdef PKT_CHECKSUM_EN
        if (idx == IDX_W'(NB + 1)) begin
            pkt_byte = checksum;
        end
`endif
    end

endmodule

// File: rtl/uart_tx_packetizer.sv
// Snapshots a multi-channel data vector and streams it as a framed packet to a byte UART.
// Build option PKT_CHECKSUM_EN inserts an XOR-of-payload checksum byte before the trailer.
module uart_tx_packetizer
    import uart_pkt_pkg::*;
#(
    parameter int         DATA_BYTES = 6,
    parameter int         NUM_CH     = 1,
    parameter logic [7:0] HEADER     = DEF_HEADER,
    parameter logic [7:0] TRAILER    = DEF_TRAILER,
    parameter int         FREE_RUN   = 1
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_Start,
    input  logic [NUM_CH*DATA_BYTES*8-1:0] i_Data,
    input  logic                           i_TX_Active,
    output logic                           o_TX_DV,
    output logic [7:0]                     o_TX_Byte,
    output logic                           o_Busy,
    output logic                           o_Pkt_Done
);

    localparam int NB    = NUM_CH * DATA_BYTES;
    localparam int PKT_L = pkt_len(NUM_CH, DATA_BYTES, CKS_EN);
    localparam int IDX_W = $clog2(PKT_L + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_L - 1);

    pkt_state_t           state;
    logic [IDX_W-1:0]     idx;
    logic [NB*8-1:0]      snapshot;
    logic                 pending;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 busy;
    logic                 pkt_done;
    logic [7:0]           sel_byte;

`ifdef PKT_CHECKSUM_EN
    logic [7:0]           checksum;
    logic [7:0]           data_xor;

    // Same value the snapshot receives in LATCH, so checksum and payload stay coherent.
    always_comb begin
        data_xor = '0;
        for (int b = 0; b < NB; b++) begin
            data_xor = data_xor ^ i_Data[b*8 +: 8];
        end
    end
`endif

    uart_pkt_byte_sel #(
        .NUM_CH     (NUM_CH),
        .DATA_BYTES (DATA_BYTES),
        .HEADER     (HEADER),
        .TRAILER    (TRAILER),
        .IDX_W      (IDX_W)
    ) u_byte_sel (
        .snapshot (snapshot),
        .idx      (idx),
`ifdef PKT_CHECKSUM_EN
        .checksum (checksum),
`endif
        .pkt_byte (sel_byte)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            snapshot <= '0;
            pending  <= 1'b0;
            tx_dv    <= 1'b0;
            tx_byte  <= '0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            tx_dv    <= 1'b0;
            pkt_done <= 1'b0;
            // One queued request at most; LATCH consumes it and ignores a same-cycle start.
            if (state != ST_LATCH && i_Start) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (!i_TX_Active && ((FREE_RUN != 0) || pending)) begin
                        state <= ST_LATCH;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    snapshot <= i_Data;
                    idx      <= '0;
                    pending  <= 1'b0;
`ifdef PKT_CHECKSUM_EN
                    checksum <= data_xor;
`endif
                    state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_byte <= sel_byte;
                    tx_dv   <= 1'b1;
                    state   <= ST_STROBE;
                end
                ST_STROBE: begin
                    state <= ST_GAP;
                end
                // GAP lets the UART raise i_TX_Active before it is sampled.
                ST_GAP: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!i_TX_Active) begin
                        if (idx == LAST_IDX) begin
                            pkt_done <= 1'b1;
                            idx      <= '0;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_TX_DV    = tx_dv;
    assign o_TX_Byte  = tx_byte;
    assign o_Busy     = busy;
    assign o_Pkt_Done = pkt_done;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Directed bench for uart_tx_packetizer: three instances (1x6 free-run, 2x2 free-run, 1x6 start-driven).
// Expected packets include the checksum byte when PKT_CHECKSUM_EN is defined.
module tb_uart_tx_packetizer;

`ifdef PKT_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int LA = 8 + CK;
    localparam int LB = 6 + CK;
    localparam int LC = 8 + CK;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [47:0] data_a = 48'h060504030201;
    logic [31:0] data_b = 32'h04030201;
    logic [47:0] data_c = 48'hA5A4A3A2A1A0;
    logic        act_a, act_b, act_c, hold_c = 1'b0;
    logic        dv_a, dv_b, dv_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [7:0]  byte_a, byte_b, byte_c;
    int          cnt_a = 0, cnt_b = 0, cnt_c = 0;

    uart_tx_packetizer #(.DATA_BYTES(6), .NUM_CH(1), .HEADER(8'hBB), .TRAILER(8'hAA), .FREE_RUN(1)) dut_a (
        .i_Clk(clk), .i_Rst(rst_a), .i_Start(start_a), .i_Data(data_a), .i_TX_Active(act_a),
        .o_TX_DV(dv_a), .o_TX_Byte(byte_a), .o_Busy(busy_a), .o_Pkt_Done(done_a));
    uart_tx_packetizer #(.DATA_BYTES(2), .NUM_CH(2), .HEADER(8'hBB), .TRAILER(8'hAA), .FREE_RUN(1)) dut_b (
        .i_Clk(clk), .i_Rst(rst_b), .i_Start(start_b), .i_Data(data_b), .i_TX_Active(act_b),
        .o_TX_DV(dv_b), .o_TX_Byte(byte_b), .o_Busy(busy_b), .o_Pkt_Done(done_b));
    uart_tx_packetizer #(.DATA_BYTES(6), .NUM_CH(1), .HEADER(8'hBB), .TRAILER(8'hAA), .FREE_RUN(0)) dut_c (
        .i_Clk(clk), .i_Rst(rst_c), .i_Start(start_c), .i_Data(data_c), .i_TX_Active(act_c),
        .o_TX_DV(dv_c), .o_TX_Byte(byte_c), .o_Busy(busy_c), .o_Pkt_Done(done_c));

    // UART models: busy for 10 cycles starting the cycle after each DV strobe.
    always @(posedge clk) begin
        if (dv_a) cnt_a <= 10; else if (cnt_a != 0) cnt_a <= cnt_a - 1;
        if (dv_b) cnt_b <= 10; else if (cnt_b != 0) cnt_b <= cnt_b - 1;
        if (dv_c) cnt_c <= 10; else if (cnt_c != 0) cnt_c <= cnt_c - 1;
    end
    assign act_a = (cnt_a != 0);
    assign act_b = (cnt_b != 0);
    assign act_c = (cnt_c != 0) || hold_c;

    logic [7:0] cap_a[$], cap_b[$], cap_c[$];
    int         done_at_a[$], done_at_b[$], done_at_c[$];
    int         viol_a = 0, viol_b = 0, viol_c = 0, busy_hi_c = 0;

    always @(negedge clk) begin
        if (dv_a) cap_a.push_back(byte_a);
        if (dv_b) cap_b.push_back(byte_b);
        if (dv_c) cap_c.push_back(byte_c);
        if (done_a) done_at_a.push_back(cap_a.size());
        if (done_b) done_at_b.push_back(cap_b.size());
        if (done_c) done_at_c.push_back(cap_c.size());
        if (dv_a && act_a) viol_a++;
        if (dv_b && act_b) viol_b++;
        if (dv_c && act_c) viol_c++;
        if (busy_c) busy_hi_c++;
    end

    typedef struct {
        int dut;
        int pos;
        int exp;
    } vec_t;
    vec_t vecs[$];

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic add_pkt(input int dut, input int base, input int bytes[$]);
        foreach (bytes[i]) vecs.push_back('{dut, base + i, bytes[i]});
    endtask

    function automatic int got(input int dut, input int pos);
        case (dut)
            0:       return (pos < cap_a.size()) ? int'(cap_a[pos]) : -1;
            1:       return (pos < cap_b.size()) ? int'(cap_b[pos]) : -1;
            default: return (pos < cap_c.size()) ? int'(cap_c[pos]) : -1;
        endcase
    endfunction

    function automatic int first_or(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    initial begin
        int pa1[$], pa3[$], pb[$], pc[$];
        int base_c, base_busy, n_done;

        pa1 = '{32'hBB, 32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06};
        pa3 = '{32'hBB, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF};
        pb  = '{32'hBB, 32'h01, 32'h02, 32'h03, 32'h04};
        pc  = '{32'hBB, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
`ifdef PKT_CHECKSUM_EN
        pa1.push_back(32'h07);
        pa3.push_back(32'h00);
        pb.push_back(32'h04);
        pc.push_back(32'h01);
`endif
        pa1.push_back(32'hAA);
        pa3.push_back(32'hAA);
        pb.push_back(32'hAA);
        pc.push_back(32'hAA);

        add_pkt(0, 0, pa1);
        add_pkt(0, LA, pa1);
        add_pkt(0, 2 * LA, pa3);
        for (int i = 0; i < 4; i++) vecs.push_back('{0, 3 * LA + i, pa3[i]});
        vecs.push_back('{0, 3 * LA + 4, 32'hBB});
        vecs.push_back('{0, 3 * LA + 5, 32'hFF});
        add_pkt(1, 0, pb);
        add_pkt(2, 0, pc);
        add_pkt(2, LC, pc);
        add_pkt(2, 2 * LC, pc);

        // Reset state
        step(3);
        check("rst_dv", int'(dv_a), 0);
        check("rst_byte", int'(byte_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_busy_c", int'(busy_c), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Free-run: first packet, then corrupt i_Data one cycle after the next LATCH
        for (int i = 0; i < 2000 && done_at_a.size() < 1; i++) step(1);
        check("a_first_done_at", first_or(done_at_a, 0), LA);
        step(2);
        data_a = 48'hFFFFFFFFFFFF;
        for (int i = 0; i < 3000 && done_at_a.size() < 3; i++) step(1);
        check("a_second_done_at", first_or(done_at_a, 1), 2 * LA);
        check("a_third_done_at", first_or(done_at_a, 2), 3 * LA);

        // Async reset while the 4th byte of packet 4 is being strobed
        for (int i = 0; i < 500 && cap_a.size() < 3 * LA + 4; i++) step(1);
        check("a_dv_before_rst", int'(dv_a), 1);
        rst_a = 1'b1;
        #1;
        check("a_dv_in_rst", int'(dv_a), 0);
        check("a_busy_in_rst", int'(busy_a), 0);
        n_done = done_at_a.size();
        step(20);
        check("a_no_done_after_rst", done_at_a.size(), n_done);
        check("a_bytes_during_rst", cap_a.size(), 3 * LA + 4);
        rst_a = 1'b0;
        for (int i = 0; i < 500 && cap_a.size() < 3 * LA + 6; i++) step(1);

        // Start-driven: nothing happens without a request
        base_c    = cap_c.size();
        base_busy = busy_hi_c;
        step(1000);
        check("c_idle_dv", cap_c.size() - base_c, 0);
        check("c_idle_busy", busy_hi_c - base_busy, 0);

        // Request queued while UART held busy for 200 cycles
        hold_c = 1'b1;
        step(1);
        start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        step(200);
        check("c_hold_dv", cap_c.size() - base_c, 0);
        check("c_hold_busy", busy_hi_c - base_busy, 0);
        hold_c = 1'b0;
        step(1);
        check("c_dv_drop_plus1", int'(dv_c), 0);
        step(1);
        check("c_dv_drop_plus2", int'(dv_c), 0);
        step(1);
        check("c_dv_drop_plus3", int'(dv_c), 1);
        for (int i = 0; i < 1000 && done_at_c.size() < 1; i++) step(1);
        step(300);
        check("c_one_pkt_bytes", cap_c.size(), LC);
        check("c_one_pkt_done", done_at_c.size(), 1);

        // One start, then three more mid-packet: exactly one extra packet
        start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        for (int i = 0; i < 100 && cap_c.size() <= LC; i++) step(1);
        for (int k = 0; k < 3; k++) begin
            step(5);
            start_c = 1'b1;
            step(1);
            start_c = 1'b0;
        end
        for (int i = 0; i < 2000 && done_at_c.size() < 3; i++) step(1);
        step(300);
        check("c_multi_bytes", cap_c.size(), 3 * LC);
        check("c_multi_done", done_at_c.size(), 3);
        check("c_done2_at", first_or(done_at_c, 1), 2 * LC);
        check("c_done3_at", first_or(done_at_c, 2), 3 * LC);

        check("b_first_done_at", first_or(done_at_b, 0), LB);
        check("a_dv_while_active", viol_a, 0);
        check("b_dv_while_active", viol_b, 0);
        check("c_dv_while_active", viol_c, 0);

        foreach (vecs[i]) begin
            check($sformatf("vec%0d_dut%0d_pos%0d", i, vecs[i].dut, vecs[i].pos),
                  got(vecs[i].dut, vecs[i].pos), vecs[i].exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_packetizer.md
Name: uart_tx_packetizer

Overview:
Generalised UART transmit framer. Snapshots a multi-channel, multi-byte data vector and streams it to the byte-wide UART transmitter as header, payload and trailer bytes. Each byte is handed over with a one-cycle data-valid strobe. The block sits between the PID datapath (tick counters, error, output terms) and the UART TX core. Transmission is either free-running whenever the UART is idle or triggered by a start pulse.

Parameters:
DATA_BYTES, 6, payload bytes per channel (1..16)
NUM_CH, 1, number of channels (1..8)
HEADER, 8'hBB, first byte of every packet
TRAILER, 8'hAA, last byte of every packet
FREE_RUN, 1, 1 = start a new packet automatically when idle; 0 = one packet per i_Start

Ports:
i_Clk  in  1  system clock, rising edge
i_Rst  in  1  asynchronous, active-high reset
i_Start  in  1  packet request; used only when FREE_RUN=0
i_Data  in  NUM_CH*DATA_BYTES*8  channel c occupies bits [(c+1)*DATA_BYTES*8-1 : c*DATA_BYTES*8]
i_TX_Active  in  1  UART transmitter busy
o_TX_DV  out  1  one-cycle byte-valid strobe to UART
o_TX_Byte  out  8  byte to transmit; stable from LOAD until the next LOAD
o_Busy  out  1  high in every state except IDLE
o_Pkt_Done  out  1  one-cycle pulse when the trailer has been accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, byte index 0, snapshot 0, pending-start 0; o_TX_DV, o_TX_Byte, o_Busy and o_Pkt_Done all 0.
- Packet order: HEADER; then ch0..ch(NUM_CH-1); within each channel bytes go LSB first; [checksum]; TRAILER.
- Packet length L = NUM_CH*DATA_BYTES + 2 (+1 with checksum). Index width is $clog2(L+1).
- FSM states: IDLE, LATCH, LOAD, STROBE, GAP, WAIT_DONE.
- IDLE: advance to LATCH when i_TX_Active=0 and (FREE_RUN=1 or pending-start=1).
- LATCH: capture the whole i_Data vector in one cycle into the snapshot, so all channels are coherent. Set index 0. Clear pending-start. Go to LOAD.
- LOAD: o_TX_Byte <= packet byte[index]. Go to STROBE.
- STROBE: o_TX_DV=1 for exactly this one cycle. Go to GAP.
- GAP: one dead cycle that gives the UART time to raise i_TX_Active. Go to WAIT_DONE.
- WAIT_DONE: stay while i_TX_Active=1. When it is 0:
  - if index = L-1: pulse o_Pkt_Done, index <= 0, go to IDLE;
  - otherwise index <= index+1, go to LOAD.
- Minimum cost is 4 cycles per byte, plus the UART busy time.
- Pending-start:
  - set by i_Start=1 in any state except LATCH; cleared in LATCH; at most one request is queued.
  - Further i_Start pulses while a request is already pending are dropped.
  - A request arriving mid-packet starts the next packet right after IDLE.
- i_Data changes after LATCH do not affect the packet in flight.
- No o_TX_DV is issued while i_TX_Active=1, except when the UART ignores the GAP cycle (UART contract).
- Reset mid-packet: abort immediately, o_TX_DV=0, no o_Pkt_Done. The receiver resynchronises on the next HEADER.
- Out-of-range FSM encoding recovers to IDLE.

Optional Feature:
PKT_CHECKSUM_EN
- Defined: one checksum byte is inserted between the last payload byte and TRAILER, and L grows by 1. The checksum is the XOR of all payload bytes; header and trailer are excluded. It is computed from the snapshot in LATCH.
- Undefined: no checksum byte and no checksum logic.

Decomposition:
- Package uart_pkt_pkg holds:
  - FSM state enum (3-bit);
  - default HEADER/TRAILER constants;
  - function pkt_len(num_ch, data_bytes, cks) returning L.
- One sub-module, uart_pkt_byte_sel: combinational mux that returns the packet byte for a given index from snapshot, HEADER, TRAILER and checksum. This keeps the FSM independent of NUM_CH and DATA_BYTES.

Test Plan:
- NUM_CH=1, DATA_BYTES=6, FREE_RUN=1, i_Data=48'h060504030201. UART model raises Active 1 cycle after DV for 10 cycles. Expect bytes BB 01 02 03 04 05 06 AA, exactly 8 DV pulses, then one o_Pkt_Done, then the next packet starts.
- NUM_CH=2, DATA_BYTES=2, i_Data=32'h04030201. Expect BB 01 02 03 04 AA. With PKT_CHECKSUM_EN, expect BB 01 02 03 04 04 AA.
- Coherency: change i_Data to 48'hFFFFFFFFFFFF on the cycle after LATCH. Expect the packet still to carry 01..06; the following packet carries FF bytes.
- FREE_RUN=0:
  - no i_Start for 1000 cycles: no DV, o_Busy=0;
  - one i_Start: exactly one packet;
  - three i_Start pulses during that packet: exactly one extra packet.
- Active held high for 200 cycles before IDLE exit. Expect no LATCH until Active drops, and the first DV exactly 3 cycles after the drop.
- Assert i_Rst asynchronously during the 4th byte. Expect DV and Busy to be 0 in the same cycle and no o_Pkt_Done. After release, the next packet starts with BB.
